// File: rtl/regfile_select_pkg.sv
// Shared CPU constants for the register-file select logic: IR field positions,
// register count and the C-field width used for sign extension.
package regfile_select_pkg;

  localparam int REG_W    = 32;
  localparam int NUM_REGS = 16;
  localparam int SEL_W    = 4;

  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  localparam int C_W = 19;

  typedef logic [SEL_W-1:0] reg_idx_t;

  // Sign-extend the instruction's C field to a full datapath word.
  function automatic logic [REG_W-1:0] c_sign_ext(input logic [C_W-1:0] c_field);
    return {{(REG_W-C_W){c_field[C_W-1]}}, c_field};
  endfunction

endpackage

// File: rtl/regfile_select_reg32.sv
// One 32-bit storage register with synchronous active-low clear and load enable.
module reg32
  import regfile_select_pkg::*;
(
  input  logic             clock,
  input  logic             clear_n,
  input  logic             en,
  input  logic [REG_W-1:0] d,
  output logic [REG_W-1:0] q
);

  logic [REG_W-1:0] r_q;

  // NOTE: state uses non-blocking assignments; clear is sampled on the edge and outranks the load.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/regfile_select.sv
// Register-file select: decodes Ra/Rb/Rc from the IR, produces one-hot read/write
// enables, muxes the selected register onto rdata and tracks select conflicts.
module regfile_select
  import regfile_select_pkg::*;
(
  input  logic                clock,
  input  logic                clear_n,
  input  logic [REG_W-1:0]    bus_in,
  input  logic [31:0]         ir,
  input  logic                gra,
  input  logic                grb,
  input  logic                grc,
  input  logic                rin,
  input  logic                rout,
  input  logic                baout,
  output logic [REG_W-1:0]    rdata,
  output logic [NUM_REGS-1:0] rin_oh,
  output logic [NUM_REGS-1:0] rout_oh,
  output logic [REG_W-1:0]    c_sign,
  output logic                sel_err
);

  logic                w_valid;
  logic                w_any_en;
  reg_idx_t            w_sel;
  logic [NUM_REGS-1:0] w_onehot;
  logic [NUM_REGS-1:0] w_rin_oh;
  logic [NUM_REGS-1:0] w_rout_oh;
  logic [REG_W-1:0]    w_rdata;
  logic [REG_W-1:0]    w_q [NUM_REGS];
  logic                r_sel_err;
  logic                w_unused_ir;

  // Exactly one of the three field selects: odd parity rules out two, the AND rules out three.
  assign w_valid  = (gra ^ grb ^ grc) & ~(gra & grb & grc);
  assign w_any_en = rin | rout | baout;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_sel = '0;
    if (gra) begin
      w_sel = ir[RA_HI:RA_LO];
    end else if (grb) begin
      w_sel = ir[RB_HI:RB_LO];
    end else if (grc) begin
      w_sel = ir[RC_HI:RC_LO];
    end
  end

  assign w_onehot  = {{(NUM_REGS-1){1'b0}}, 1'b1} << w_sel;
  assign w_rin_oh  = (rin && w_valid)            ? w_onehot : '0;
  assign w_rout_oh = ((rout || baout) && w_valid) ? w_onehot : '0;

  // baout wins over rout, so R0 reads as zero whenever baout is asserted.
  always_comb begin
    w_rdata = '0;
    if (w_rout_oh != '0) begin
      if (baout && (w_sel == '0)) begin
        w_rdata = '0;
      end else begin
        w_rdata = w_q[w_sel];
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    reg32 u_reg (
      .clock   (clock),
      .clear_n (clear_n),
      .en      (w_rin_oh[i]),
      .d       (bus_in),
      .q       (w_q[i])
    );
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_sel_err <= 1'b0;
    end else if (w_any_en && !w_valid) begin
      r_sel_err <= 1'b1;
    end
  end

  // Opcode bits are not used by this block.
  assign w_unused_ir = ^ir[31:RA_HI+1];

  assign rdata   = w_rdata;
  assign rin_oh  = w_rin_oh;
  assign rout_oh = w_rout_oh;
  assign c_sign  = c_sign_ext(ir[C_W-1:0]);
  assign sel_err = r_sel_err;

endmodule

// File: tb/tb_regfile_select.sv
// Self-checking bench for regfile_select: directed vector table, hand sequences
// for sticky error / reset corners, then random stimulus against a behavioural model.
module tb_regfile_select;

  logic        clock = 1'b0;
  logic        clear_n;
  logic [31:0] bus_in;
  logic [31:0] ir;
  logic        gra, grb, grc;
  logic        rin, rout, baout;
  logic [31:0] rdata;
  logic [15:0] rin_oh;
  logic [15:0] rout_oh;
  logic [31:0] c_sign;
  logic        sel_err;

  regfile_select dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus_in  (bus_in),
    .ir      (ir),
    .gra     (gra),
    .grb     (grb),
    .grc     (grc),
    .rin     (rin),
    .rout    (rout),
    .baout   (baout),
    .rdata   (rdata),
    .rin_oh  (rin_oh),
    .rout_oh (rout_oh),
    .c_sign  (c_sign),
    .sel_err (sel_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register contents and sticky error flag.
  logic [31:0] m_regs [16];
  logic        m_err = 1'b0;

  function automatic int n_selects();
    return int'(gra) + int'(grb) + int'(grc);
  endfunction

  function automatic int field_idx();
    if (gra) return int'(ir[26:23]);
    if (grb) return int'(ir[22:19]);
    return int'(ir[18:15]);
  endfunction

  function automatic logic [31:0] exp_c_sign();
    int v;
    v = int'(ir[18:0]);
    if (ir[18]) v = v - (1 << 19);
    return 32'(v);
  endfunction

  task automatic model_edge();
    if (!clear_n) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_err = 1'b0;
    end else begin
      if (rin && n_selects() == 1) m_regs[field_idx()] = bus_in;
      if ((rin || rout || baout) && n_selects() != 1) m_err = 1'b1;
    end
  endtask

  typedef struct {
    logic        clear_n;
    logic [31:0] ir;
    logic [2:0]  g;    // {gra, grb, grc}
    logic [2:0]  en;   // {rin, rout, baout}
    logic [31:0] bus;
    logic [15:0] x_rin_oh;
    logic [15:0] x_rout_oh;
    logic [31:0] x_rdata;
    logic        x_err;
  } vec_t;

  function automatic vec_t mk(logic cn, logic [31:0] i_ir, logic [2:0] g, logic [2:0] en,
                              logic [31:0] bus, logic [15:0] xri, logic [15:0] xro,
                              logic [31:0] xrd, logic xe);
    vec_t v;
    v.clear_n = cn; v.ir = i_ir; v.g = g; v.en = en; v.bus = bus;
    v.x_rin_oh = xri; v.x_rout_oh = xro; v.x_rdata = xrd; v.x_err = xe;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    clear_n = v.clear_n;
    ir      = v.ir;
    {gra, grb, grc}    = v.g;
    {rin, rout, baout} = v.en;
    bus_in  = v.bus;
  endtask

  // Apply at negedge, check combinational outputs, clock, check sel_err after the edge.
  task automatic run_vec(input string tag, input vec_t v);
    @(negedge clock);
    apply(v);
    #1;
    check({tag, ".rin_oh"},  32'(rin_oh),  32'(v.x_rin_oh));
    check({tag, ".rout_oh"}, 32'(rout_oh), 32'(v.x_rout_oh));
    check({tag, ".rdata"},   rdata,        v.x_rdata);
    @(posedge clock);
    model_edge();
    #1;
    check({tag, ".sel_err"}, 32'(sel_err), 32'(v.x_err));
  endtask

  localparam logic [31:0] IR_RA3 = 32'h0180_0000;
  localparam logic [31:0] IR_RA5 = 32'h0280_0000;
  localparam logic [31:0] IR_RC7 = 32'h0003_8000;

  vec_t tbl [14];

  initial begin
    vec_t v;
    logic [31:0] x_rd;
    logic [15:0] x_oh;
    int n, f;

    foreach (m_regs[i]) m_regs[i] = 32'h0;
    apply(mk(1'b0, 32'h0, 3'b000, 3'b000, 32'h0, 16'h0, 16'h0, 32'h0, 1'b0));

    tbl[0]  = mk(1'b0, 32'h0,  3'b000, 3'b000, 32'h0,         16'h0000, 16'h0000, 32'h0,         1'b0);
    tbl[1]  = mk(1'b1, IR_RA3, 3'b100, 3'b010, 32'h0,         16'h0000, 16'h0008, 32'h0,         1'b0);
    tbl[2]  = mk(1'b1, IR_RA5, 3'b100, 3'b100, 32'hDEAD_BEEF, 16'h0020, 16'h0000, 32'h0,         1'b0);
    tbl[3]  = mk(1'b1, IR_RA5, 3'b100, 3'b010, 32'h0,         16'h0000, 16'h0020, 32'hDEAD_BEEF, 1'b0);
    tbl[4]  = mk(1'b1, IR_RA5, 3'b100, 3'b110, 32'h1111_1111, 16'h0020, 16'h0020, 32'hDEAD_BEEF, 1'b0);
    tbl[5]  = mk(1'b1, IR_RA5, 3'b100, 3'b010, 32'h0,         16'h0000, 16'h0020, 32'h1111_1111, 1'b0);
    tbl[6]  = mk(1'b1, 32'h0,  3'b010, 3'b100, 32'h0000_1234, 16'h0001, 16'h0000, 32'h0,         1'b0);
    tbl[7]  = mk(1'b1, 32'h0,  3'b010, 3'b001, 32'h0,         16'h0000, 16'h0001, 32'h0,         1'b0);
    tbl[8]  = mk(1'b1, 32'h0,  3'b010, 3'b011, 32'h0,         16'h0000, 16'h0001, 32'h0,         1'b0);
    tbl[9]  = mk(1'b1, 32'h0,  3'b010, 3'b010, 32'h0,         16'h0000, 16'h0001, 32'h0000_1234, 1'b0);
    tbl[10] = mk(1'b1, IR_RA5, 3'b110, 3'b000, 32'hFFFF_FFFF, 16'h0000, 16'h0000, 32'h0,         1'b0);
    tbl[11] = mk(1'b1, IR_RA5, 3'b110, 3'b100, 32'hFFFF_FFFF, 16'h0000, 16'h0000, 32'h0,         1'b1);
    tbl[12] = mk(1'b1, IR_RA5, 3'b100, 3'b010, 32'h0,         16'h0000, 16'h0020, 32'h1111_1111, 1'b1);
    tbl[13] = mk(1'b1, IR_RA5, 3'b010, 3'b010, 32'h0,         16'h0000, 16'h0001, 32'h0000_1234, 1'b1);

    for (int i = 0; i < 14; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Sticky error survives idle cycles, then a single reset edge clears it.
    for (int i = 0; i < 10; i++)
      run_vec("idle", mk(1'b1, IR_RA5, 3'b110, 3'b000, 32'h0, 16'h0, 16'h0, 32'h0, 1'b1));
    run_vec("rst_err", mk(1'b0, 32'h0, 3'b000, 3'b000, 32'h0, 16'h0, 16'h0, 32'h0, 1'b0));
    run_vec("r0_clr",  mk(1'b1, 32'h0, 3'b010, 3'b010, 32'h0, 16'h0, 16'h0001, 32'h0, 1'b0));

    // Reset takes priority over a simultaneous write.
    run_vec("r7_wr",  mk(1'b1, IR_RC7, 3'b001, 3'b100, 32'hA5A5_A5A5, 16'h0080, 16'h0, 32'h0, 1'b0));
    run_vec("r7_rd",  mk(1'b1, IR_RC7, 3'b001, 3'b010, 32'h0, 16'h0, 16'h0080, 32'hA5A5_A5A5, 1'b0));
    run_vec("r7_rst", mk(1'b0, IR_RC7, 3'b001, 3'b100, 32'h1, 16'h0080, 16'h0, 32'h0, 1'b0));
    run_vec("r7_rd0", mk(1'b1, IR_RC7, 3'b001, 3'b010, 32'h0, 16'h0, 16'h0080, 32'h0, 1'b0));
    run_vec("nosel",  mk(1'b1, IR_RC7, 3'b000, 3'b010, 32'h0, 16'h0, 16'h0, 32'h0, 1'b1));

    @(negedge clock);
    ir = 32'h0004_0000; #1;
    check("c_sign_neg", c_sign, 32'hFFFC_0000);
    ir = 32'h0003_FFFF; #1;
    check("c_sign_pos", c_sign, 32'h0003_FFFF);

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      clear_n = ($urandom_range(31) != 0);
      ir      = $urandom;
      bus_in  = $urandom;
      if ($urandom_range(3) == 0) {gra, grb, grc} = 3'($urandom);
      else {gra, grb, grc} = 3'b001 << $urandom_range(2);
      {rin, rout, baout} = 3'($urandom);
      #1;
      n = n_selects();
      f = field_idx();
      x_oh = (n == 1) ? 16'(1 << f) : 16'h0;
      x_rd = 32'h0;
      if ((rout || baout) && n == 1 && !(baout && f == 0)) x_rd = m_regs[f];
      check("rnd.rin_oh",  32'(rin_oh),  32'(rin ? x_oh : 16'h0));
      check("rnd.rout_oh", 32'(rout_oh), 32'((rout || baout) ? x_oh : 16'h0));
      check("rnd.rdata",   rdata,        x_rd);
      check("rnd.c_sign",  c_sign,       exp_c_sign());
      @(posedge clock);
      model_edge();
      #1;
      check("rnd.sel_err", 32'(sel_err), 32'(m_err));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
